led_to_bin: RTL and testbench



---
 rtl/led_to_bin_if.sv | 29 ++
 rtl/led_to_bin.sv | 116 +++++++++++
 tb/tb_led_to_bin.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/led_to_bin_if.sv
// Bundles the start request, the eight captured digit patterns and the result/status
// signals exchanged between a requester (master) and the led_to_bin decoder (slave).
interface led_to_bin_if;
  logic        start;
  logic [7:0]  led_high;
  logic [7:0]  led_middle_6;
  logic [7:0]  led_middle_5;
  logic [7:0]  led_middle_4;
  logic [7:0]  led_middle_3;
  logic [7:0]  led_middle_2;
  logic [7:0]  led_middle_1;
  logic [7:0]  led_low;
  logic [27:0] out;
  logic        err;
  logic        busy;
  logic        done;

  modport master (
    output start, led_high, led_middle_6, led_middle_5, led_middle_4,
           led_middle_3, led_middle_2, led_middle_1, led_low,
    input  out, err, busy, done
  );

  modport slave (
    input  start, led_high, led_middle_6, led_middle_5, led_middle_4,
           led_middle_3, led_middle_2, led_middle_1, led_low,
    output out, err, busy, done
  );
endinterface

// File: rtl/led_to_bin.sv
// Decodes eight captured 7-segment patterns (a..g,dp) back to BCD digits, high digit
// first, and folds them into a 28-bit binary value with acc = acc*10 + digit.
module led_to_bin #(
  parameter bit DP_MASK    = 1'b1,
  parameter bit BLANK_ZERO = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  led_to_bin_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [7:0][7:0] cap_q, cap_d;
  logic [27:0]     acc_q, acc_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            errf_q, errf_d;
  logic [27:0]     out_q, out_d;
  logic            err_q, err_d;

  logic [3:0]      curDigit;
  logic            curInvalid;
  logic [27:0]     accNext;

  // Returns {invalid, digit}; an unrecognised pattern yields digit 0 with invalid set.
  function automatic logic [4:0] decodeDigit(input logic [7:0] pattern);
    logic [7:0] seg;
    seg = DP_MASK ? {pattern[7:1], 1'b0} : pattern;
    case (seg)
      8'hFC:   decodeDigit = {1'b0, 4'd0};
      8'h60:   decodeDigit = {1'b0, 4'd1};
      8'hDA:   decodeDigit = {1'b0, 4'd2};
      8'hF2:   decodeDigit = {1'b0, 4'd3};
      8'h66:   decodeDigit = {1'b0, 4'd4};
      8'hB6:   decodeDigit = {1'b0, 4'd5};
      8'hBE:   decodeDigit = {1'b0, 4'd6};
      8'hE0:   decodeDigit = {1'b0, 4'd7};
      8'hFE:   decodeDigit = {1'b0, 4'd8};
      8'hF6:   decodeDigit = {1'b0, 4'd9};
      8'h00:   decodeDigit = BLANK_ZERO ? {1'b0, 4'd0} : {1'b1, 4'd0};
      default: decodeDigit = {1'b1, 4'd0};
    endcase
  endfunction

  always_comb begin
    {curInvalid, curDigit} = decodeDigit(cap_q[cnt_q]);
    accNext = (acc_q << 3) + (acc_q << 1) + {24'd0, curDigit};

    state_d = state_q;
    cap_d   = cap_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    errf_d  = errf_q;
    out_d   = out_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Index 0 holds the most significant digit so cnt walks high to low.
          cap_d   = {bus.led_low, bus.led_middle_1, bus.led_middle_2, bus.led_middle_3,
                     bus.led_middle_4, bus.led_middle_5, bus.led_middle_6, bus.led_high};
          acc_d   = '0;
          cnt_d   = '0;
          errf_d  = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d  = accNext;
        errf_d = errf_q | curInvalid;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          out_d   = (errf_q | curInvalid) ? '0 : accNext;
          err_d   = errf_q | curInvalid;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cap_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      errf_q  <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      errf_q  <= errf_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.err  = err_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_led_to_bin.sv
// Directed bench for led_to_bin: three parameterisations share identical stimulus so
// the DP_MASK and BLANK_ZERO variants can be compared against hand-computed results.
module tb_led_to_bin;

  localparam logic [63:0] P12345678 = 64'h60DAF266B6BEE0FE;
  localparam logic [63:0] PNINES    = 64'hF6F6F6F6F6F6F6F6;
  localparam logic [63:0] PZEROS    = 64'hFCFCFCFCFCFCFCFC;
  localparam logic [63:0] PBADMID3  = 64'h60DAF26655BEE0FE;
  localparam logic [63:0] PDOTZERO  = 64'hFDFDFDFDFDFDFDFD;
  localparam logic [63:0] PBLANKHI  = 64'h00DAF266B6BEE0FE;
  localparam logic [63:0] PA        = 64'hFEE0BEB666F2DA60;
  localparam logic [63:0] PB        = 64'hDA66BEFE60F2B6E0;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   failCount;

  led_to_bin_if ifMain ();
  led_to_bin_if ifNoDp ();
  led_to_bin_if ifBlank ();

  led_to_bin #(.DP_MASK(1'b1), .BLANK_ZERO(1'b0)) dutMain (
    .clk(clk), .rst_n(rst_n), .bus(ifMain)
  );
  led_to_bin #(.DP_MASK(1'b0), .BLANK_ZERO(1'b0)) dutNoDp (
    .clk(clk), .rst_n(rst_n), .bus(ifNoDp)
  );
  led_to_bin #(.DP_MASK(1'b1), .BLANK_ZERO(1'b1)) dutBlank (
    .clk(clk), .rst_n(rst_n), .bus(ifBlank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] pats, input logic startVal);
    ifMain.start = startVal;   ifNoDp.start = startVal;   ifBlank.start = startVal;
    ifMain.led_high     = pats[63:56]; ifNoDp.led_high     = pats[63:56]; ifBlank.led_high     = pats[63:56];
    ifMain.led_middle_6 = pats[55:48]; ifNoDp.led_middle_6 = pats[55:48]; ifBlank.led_middle_6 = pats[55:48];
    ifMain.led_middle_5 = pats[47:40]; ifNoDp.led_middle_5 = pats[47:40]; ifBlank.led_middle_5 = pats[47:40];
    ifMain.led_middle_4 = pats[39:32]; ifNoDp.led_middle_4 = pats[39:32]; ifBlank.led_middle_4 = pats[39:32];
    ifMain.led_middle_3 = pats[31:24]; ifNoDp.led_middle_3 = pats[31:24]; ifBlank.led_middle_3 = pats[31:24];
    ifMain.led_middle_2 = pats[23:16]; ifNoDp.led_middle_2 = pats[23:16]; ifBlank.led_middle_2 = pats[23:16];
    ifMain.led_middle_1 = pats[15:8];  ifNoDp.led_middle_1 = pats[15:8];  ifBlank.led_middle_1 = pats[15:8];
    ifMain.led_low      = pats[7:0];   ifNoDp.led_low      = pats[7:0];   ifBlank.led_low      = pats[7:0];
  endtask

  // One start pulse, then a bounded wait for done; the result stays held for the caller.
  task automatic doConversion(input logic [63:0] pats, input string name);
    int edges;
    bit seen;
    @(negedge clk);
    applyStimulus(pats, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(pats, 1'b0);
    checkOutput({name, " busy after start"}, {31'd0, ifMain.busy}, 32'd1);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (ifMain.done) seen = 1'b1;
    end
    checkOutput({name, " done latency"}, edges, 32'd8);
    checkOutput({name, " busy in done cycle"}, {31'd0, ifMain.busy}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput({name, " done one cycle"}, {31'd0, ifMain.done}, 32'd0);
    checkOutput({name, " idle after done"}, {31'd0, ifMain.busy}, 32'd0);
  endtask

  initial begin
    int doneSeen;
    checkCount = 0;
    failCount  = 0;
    rst_n = 1'b0;
    applyStimulus(64'd0, 1'b0);
    #3;
    checkOutput("reset out", {4'd0, ifMain.out}, 32'd0);
    checkOutput("reset err", {31'd0, ifMain.err}, 32'd0);
    checkOutput("reset busy", {31'd0, ifMain.busy}, 32'd0);
    checkOutput("reset done", {31'd0, ifMain.done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    doConversion(P12345678, "t1");
    checkOutput("t1 out", {4'd0, ifMain.out}, 32'd12345678);
    checkOutput("t1 err", {31'd0, ifMain.err}, 32'd0);

    doConversion(PNINES, "t2 nines");
    checkOutput("t2 nines out", {4'd0, ifMain.out}, 32'd99999999);
    checkOutput("t2 nines err", {31'd0, ifMain.err}, 32'd0);
    doConversion(PZEROS, "t2 zeros");
    checkOutput("t2 zeros out", {4'd0, ifMain.out}, 32'd0);
    checkOutput("t2 zeros err", {31'd0, ifMain.err}, 32'd0);

    doConversion(PBADMID3, "t3 bad");
    checkOutput("t3 bad out", {4'd0, ifMain.out}, 32'd0);
    checkOutput("t3 bad err", {31'd0, ifMain.err}, 32'd1);
    doConversion(P12345678, "t3 recover");
    checkOutput("t3 recover out", {4'd0, ifMain.out}, 32'd12345678);
    checkOutput("t3 recover err", {31'd0, ifMain.err}, 32'd0);

    doConversion(PDOTZERO, "t4 dp");
    checkOutput("t4 dp masked out", {4'd0, ifMain.out}, 32'd0);
    checkOutput("t4 dp masked err", {31'd0, ifMain.err}, 32'd0);
    checkOutput("t4 dp unmasked out", {4'd0, ifNoDp.out}, 32'd0);
    checkOutput("t4 dp unmasked err", {31'd0, ifNoDp.err}, 32'd1);
    doConversion(PBLANKHI, "t4 blank");
    checkOutput("t4 blank allowed out", {4'd0, ifBlank.out}, 32'd2345678);
    checkOutput("t4 blank allowed err", {31'd0, ifBlank.err}, 32'd0);
    checkOutput("t4 blank rejected out", {4'd0, ifMain.out}, 32'd0);
    checkOutput("t4 blank rejected err", {31'd0, ifMain.err}, 32'd1);

    // start held high; only the patterns present at capture edges N and N+10 matter.
    @(negedge clk);
    applyStimulus(PA, 1'b1);
    @(posedge clk);
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (e == 10)        applyStimulus(PB, 1'b1);
      else if (e == 20)   applyStimulus({8{8'h55}}, 1'b0);
      else if (e % 2 == 1) applyStimulus({8{8'h55}}, 1'b1);
      else                applyStimulus({8{8'hFE}}, 1'b1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("t5 done edge %0d", e), {31'd0, ifMain.done},
                  (e == 8 || e == 18) ? 32'd1 : 32'd0);
      if (e == 8) begin
        checkOutput("t5 first out", {4'd0, ifMain.out}, 32'd87654321);
        checkOutput("t5 first err", {31'd0, ifMain.err}, 32'd0);
      end
      if (e == 18) begin
        checkOutput("t5 second out", {4'd0, ifMain.out}, 32'd24681357);
        checkOutput("t5 second err", {31'd0, ifMain.err}, 32'd0);
      end
    end
    checkOutput("t5 idle after", {31'd0, ifMain.busy}, 32'd0);

    @(negedge clk);
    applyStimulus(P12345678, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(P12345678, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 reset busy", {31'd0, ifMain.busy}, 32'd0);
    checkOutput("t6 reset done", {31'd0, ifMain.done}, 32'd0);
    checkOutput("t6 reset out", {4'd0, ifMain.out}, 32'd0);
    checkOutput("t6 reset err", {31'd0, ifMain.err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (ifMain.done) doneSeen++;
    end
    checkOutput("t6 no done after abort", doneSeen, 32'd0);
    doConversion(P12345678, "t6 restart");
    checkOutput("t6 restart out", {4'd0, ifMain.out}, 32'd12345678);
    checkOutput("t6 restart err", {31'd0, ifMain.err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
